// File: rtl/vx_scoreboard_pkg.sv
// Shared constants and helpers for the register-hazard scoreboard.
// Optional WAW destination check is enabled by defining VX_SB_WAW_CHECK_EN.
package vx_scoreboard_pkg;

   localparam logic       STALL   = 1'b1;
   localparam logic [1:0] NO_WB   = 2'b00;
   localparam logic [1:0] CNT_MAX = 2'b11;

   function automatic int warp_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // x0 is hardwired, and indices beyond the register file are never tracked
   function automatic logic reg_tracked(input logic [4:0] r, input int n);
      return (r != 5'd0) && (int'(r) < n);
   endfunction

endpackage

// File: rtl/vx_sb_counter.sv
// Two-bit saturating pending-writer counter for one (warp, register) entry.
// Net update is inc minus both releases; a result below zero clamps and flags underflow.
module vx_sb_counter
   import vx_scoreboard_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       dec_a,
   input  logic       dec_b,
   output logic [1:0] cnt,
   output logic       underflow,
   output logic       zero_next
);

   logic [1:0] cnt_r;
   logic [1:0] cnt_next_s;
   logic [2:0] up_s;
   logic [2:0] dec_s;
   logic [2:0] diff_s;
   logic       underflow_s;

   // Next count with clamp at zero and saturation at the top
   always_comb begin
      up_s        = {1'b0, cnt_r} + {2'b00, inc};
      dec_s       = {2'b00, dec_a} + {2'b00, dec_b};
      diff_s      = up_s - dec_s;
      underflow_s = 1'b0;
      cnt_next_s  = cnt_r;
      if (up_s < dec_s) begin
         cnt_next_s  = 2'b00;
         underflow_s = 1'b1;
      end else if (diff_s > {1'b0, CNT_MAX}) begin
         cnt_next_s  = CNT_MAX;
      end else begin
         cnt_next_s  = diff_s[1:0];
      end
   end

   // Counter state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 2'b00;
      end else begin
         cnt_r <= cnt_next_s;
      end
   end

   assign cnt       = cnt_r;
   assign underflow = underflow_s;
   assign zero_next = (cnt_next_s == 2'b00);

endmodule

// File: rtl/vx_scoreboard.sv
// Register-hazard scoreboard driving the decode/execute forwarding stall.
// Define VX_SB_WAW_CHECK_EN to also stall a writer whose destination is still pending.
module vx_scoreboard
   import vx_scoreboard_pkg::*;
#(
   parameter  int NUM_WARPS = 8,
   parameter  int NUM_REGS  = 32,
   localparam int WW        = warp_width(NUM_WARPS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_issue_valid,
   input  logic [WW-1:0]        in_warp_num,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic                 in_uses_rs1,
   input  logic                 in_uses_rs2,
   input  logic [1:0]           in_wb,
   input  logic                 in_freeze,
   input  logic                 in_wb_valid,
   input  logic [WW-1:0]        in_wb_warp_num,
   input  logic [4:0]           in_wb_rd,
   input  logic                 in_kill_valid,
   input  logic [WW-1:0]        in_kill_warp_num,
   input  logic [4:0]           in_kill_rd,
   output logic                 out_fwd_stall,
   output logic [NUM_WARPS-1:0] out_warp_idle,
   output logic                 out_sb_error
);

   localparam int NE = NUM_WARPS * NUM_REGS;

   logic [2*NE-1:0]      cnt_flat_s;
   logic [NE-1:0]        zero_next_s;
   logic [NE-1:0]        underflow_s;
   logic [NUM_WARPS-1:0] idle_next_s;
   logic [NUM_WARPS-1:0] warp_idle_r;
   logic                 sb_error_r;

   logic [1:0] cnt_rs1_s;
   logic [1:0] cnt_rs2_s;
   logic [1:0] cnt_rd_s;
   logic       bypass_rs1_s;
   logic       bypass_rs2_s;
   logic       rs1_haz_s;
   logic       rs2_haz_s;
   logic       rd_haz_s;
   logic       hazard_s;
   logic       accept_s;
   logic       wb_rel_s;
   logic       kill_rel_s;
   int         base_s;

   // Hazard detection against current counters with writeback bypass on sources
   always_comb begin
      base_s       = int'(in_warp_num) * NUM_REGS;
      cnt_rs1_s    = cnt_flat_s[2*(base_s + int'(in_rs1)) +: 2];
      cnt_rs2_s    = cnt_flat_s[2*(base_s + int'(in_rs2)) +: 2];
      cnt_rd_s     = cnt_flat_s[2*(base_s + int'(in_rd)) +: 2];
      bypass_rs1_s = in_wb_valid && (in_wb_warp_num == in_warp_num) &&
                     (in_wb_rd == in_rs1) && (cnt_rs1_s == 2'b01);
      bypass_rs2_s = in_wb_valid && (in_wb_warp_num == in_warp_num) &&
                     (in_wb_rd == in_rs2) && (cnt_rs2_s == 2'b01);
      rs1_haz_s    = in_uses_rs1 && reg_tracked(in_rs1, NUM_REGS) &&
                     (cnt_rs1_s != 2'b00) && !bypass_rs1_s;
      rs2_haz_s    = in_uses_rs2 && reg_tracked(in_rs2, NUM_REGS) &&
                     (cnt_rs2_s != 2'b00) && !bypass_rs2_s;
`ifdef VX_SB_WAW_CHECK_EN
      rd_haz_s     = (in_wb != NO_WB) && reg_tracked(in_rd, NUM_REGS) &&
                     (cnt_rd_s != 2'b00);
`else
      rd_haz_s     = (in_wb != NO_WB) && reg_tracked(in_rd, NUM_REGS) &&
                     (cnt_rd_s == CNT_MAX);
`endif
      hazard_s     = in_issue_valid && (rs1_haz_s || rs2_haz_s || rd_haz_s);
      accept_s     = in_issue_valid && !hazard_s && !in_freeze &&
                     (in_wb != NO_WB) && reg_tracked(in_rd, NUM_REGS);
      wb_rel_s     = in_wb_valid && reg_tracked(in_wb_rd, NUM_REGS);
      kill_rel_s   = in_kill_valid && reg_tracked(in_kill_rd, NUM_REGS);
   end

   for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
      for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
         if (r == 0) begin : g_x0
            assign cnt_flat_s[2*(w*NUM_REGS + r) +: 2] = 2'b00;
            assign zero_next_s[w*NUM_REGS + r]         = 1'b1;
            assign underflow_s[w*NUM_REGS + r]         = 1'b0;
         end else begin : g_cnt
            vx_sb_counter u_cnt (
               .clk       (clk),
               .rst_n     (reset),
               .inc       (accept_s && (in_warp_num == WW'(w)) && (in_rd == 5'(r))),
               .dec_a     (wb_rel_s && (in_wb_warp_num == WW'(w)) && (in_wb_rd == 5'(r))),
               .dec_b     (kill_rel_s && (in_kill_warp_num == WW'(w)) && (in_kill_rd == 5'(r))),
               .cnt       (cnt_flat_s[2*(w*NUM_REGS + r) +: 2]),
               .underflow (underflow_s[w*NUM_REGS + r]),
               .zero_next (zero_next_s[w*NUM_REGS + r])
            );
         end
      end
      assign idle_next_s[w] = &zero_next_s[w*NUM_REGS +: NUM_REGS];
   end

   // Idle flags follow next-state; error is sticky until reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         warp_idle_r <= {NUM_WARPS{1'b1}};
         sb_error_r  <= 1'b0;
      end else begin
         warp_idle_r <= idle_next_s;
         sb_error_r  <= sb_error_r | (|underflow_s);
      end
   end

   assign out_fwd_stall = hazard_s ? STALL : ~STALL;
   assign out_warp_idle = warp_idle_r;
   assign out_sb_error  = sb_error_r;

endmodule
